ia_frame_loader: RTL

- Parametrised successor to the fixed 61-byte UART register loader.
- Consumes a byte stream from the UART receiver (one-cycle rx_valid strobes) and frames it as header, NUM_BYTES payload bytes and a checksum trailer.
- Issues an indexed register write per payload byte, then a one-cycle frame_done on a good frame or frame_err with a cause code.
- Adds an inter-byte timeout so a dropped byte cannot desynchronise the loader permanently.

---
 rtl/ia_frame_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ia_frame_loader.sv
// ia_frame_loader
// ---------------
// Frames the byte stream from the UART receiver into one register-load
// transaction. A frame has an optional sync header, NUM_BYTES payload bytes
// and an optional 8-bit additive checksum trailer. Each payload byte becomes
// one indexed register write. A frame ends with a one-cycle frame_done when
// it is good, or with a one-cycle frame_err and a cause code when it is
// aborted. An inter-byte timeout keeps a dropped byte from leaving the loader
// stuck inside a frame.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high; dominates every other input
//   rx_data      received byte, meaningful only while rx_valid = 1
//   rx_valid     one-cycle strobe per received byte
//   wr_en        one-cycle register write strobe
//   wr_idx       payload index of the write, 0..NUM_BYTES-1
//   wr_data      payload byte of the write
//   frame_start  one-cycle pulse when a frame begins
//   frame_done   one-cycle pulse when a frame completes good
//   frame_err    one-cycle pulse when a frame is aborted
//   err_code     01 = timeout, 10 = checksum mismatch; held until the next
//                frame_start
//   busy         high while inside a frame (payload or checksum phase)
//
// Every output is registered: the response to a byte is visible in the cycle
// after its rx_valid strobe.

module ia_frame_loader #(
  parameter int          NUM_BYTES      = 61,
  parameter int          IDX_W          = $clog2(NUM_BYTES),
  parameter bit          HEADER_EN      = 1'b1,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter bit          CHK_EN         = 1'b1,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [7:0]       wr_data,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHKSUM  = 2'b10;

  // The counter only has to reach TIMEOUT_CYCLES-1: expiry is declared on
  // the idle cycle that would take it to TIMEOUT_CYCLES.
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] index, index_n;
  logic [7:0]       checksum, checksum_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic             wr_en_n;
  logic [IDX_W-1:0] wr_idx_n;
  logic [7:0]       wr_data_n;
  logic             frame_start_n;
  logic             frame_done_n;
  logic             frame_err_n;
  logic [1:0]       err_code_n;
  logic             timeout_hit;

  // The timeout fires when an idle cycle inside a frame would carry the
  // counter up to TIMEOUT_CYCLES. A byte in that same cycle takes priority,
  // which the state logic below gets by testing rx_valid first.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));

  // All state and all outputs are registered together. Reset puts the loader
  // back in IDLE with every output low, so a reset mid-frame produces no
  // completion or error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      index       <= '0;
      checksum    <= '0;
      cnt         <= '0;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      index       <= index_n;
      checksum    <= checksum_n;
      cnt         <= cnt_n;
      wr_en       <= wr_en_n;
      wr_idx      <= wr_idx_n;
      wr_data     <= wr_data_n;
      frame_start <= frame_start_n;
      frame_done  <= frame_done_n;
      frame_err   <= frame_err_n;
      err_code    <= err_code_n;
      busy        <= (state_n != ST_IDLE);
    end
  end

  // Next-state and next-output logic. Pulses default low and everything else
  // defaults to holding its value; wr_idx/wr_data only change on a write.
  // Inside a frame any byte, including one equal to HEADER, is data.
  always_comb begin
    state_n       = state;
    index_n       = index;
    checksum_n    = checksum;
    cnt_n         = cnt;
    wr_en_n       = 1'b0;
    wr_idx_n      = wr_idx;
    wr_data_n     = wr_data;
    frame_start_n = 1'b0;
    frame_done_n  = 1'b0;
    frame_err_n   = 1'b0;
    err_code_n    = err_code;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (rx_valid) begin
          if (HEADER_EN) begin
            if (rx_data == HEADER) begin
              frame_start_n = 1'b1;
              err_code_n    = ERR_NONE;
              index_n       = '0;
              checksum_n    = '0;
              state_n       = ST_PAYLOAD;
            end
          end else begin
            // Headerless framing: the opening byte is payload byte 0.
            frame_start_n = 1'b1;
            err_code_n    = ERR_NONE;
            wr_en_n       = 1'b1;
            wr_idx_n      = '0;
            wr_data_n     = rx_data;
            checksum_n    = rx_data;
            index_n       = IDX_W'(1);
            state_n       = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          cnt_n      = '0;
          wr_en_n    = 1'b1;
          wr_idx_n   = index;
          wr_data_n  = rx_data;
          checksum_n = checksum + rx_data;
          if (index == LAST_IDX) begin
            if (CHK_EN) begin
              state_n = ST_CHECK;
            end else begin
              frame_done_n = 1'b1;
              state_n      = ST_IDLE;
            end
          end else begin
            index_n = index + IDX_W'(1);
          end
        end else if (timeout_hit) begin
          frame_err_n = 1'b1;
          err_code_n  = ERR_TIMEOUT;
          cnt_n       = '0;
          state_n     = ST_IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (rx_valid) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          if (rx_data == checksum) begin
            frame_done_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
            err_code_n  = ERR_CHKSUM;
          end
        end else if (timeout_hit) begin
          frame_err_n = 1'b1;
          err_code_n  = ERR_TIMEOUT;
          cnt_n       = '0;
          state_n     = ST_IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
